nim_score_tracker: RTL
======================

// Module: nim_score_tracker
// PURPOSE
//  Multi-player guess scorer for the Nim/guess game datapath. Captures a keypad entry on the key_valid
//  rising edge and compares it with the motor/target value. It then adds 1 to or subtracts 1 from the
//  selected player's BCD score, holds off further input for a lockout window, and reports the leader.
//  Sits between the keypad decoder/motor controller and the 4-digit seven-segment mux, which takes score_bcd slices.
// PARAMETERS
//  VAL_W       4   width of key_value / target_value
//  DIGITS      2   BCD digits per score (max score = 10^DIGITS-1), 1..4
//  PLAYERS     2   number of score channels, 1..4
//  LOCK_CYCLES 4   lockout cycles after each scored event, >=1
//  WRAP_ON_MAX 0   1: score at max wraps to 0 on hit; 0: saturates at max
// PORTS
//  clk          in   1                    clock
//  reset        in   1                    synchronous, active-high
//  key_valid    in   1                    keypad entry valid (level; may be held many cycles)
//  key_value    in   VAL_W                entered value
//  target_value in   VAL_W                current motor/target value
//  player_sel   in   PW=max(1,$clog2(PLAYERS))  player credited for the entry
//  score_bcd    out  PLAYERS*DIGITS*4     scores; player p = [p*DIGITS*4 +: DIGITS*4], LS digit lowest
//  hit          out  1                    1-cycle pulse: entry matched
//  miss         out  1                    1-cycle pulse: entry did not match
//  busy         out  1                    high in EVAL and LOCK states
//  leader       out  PW                   index of the highest score; ties go to the lowest index
// BEHAVIOUR
//  Reset: reset is synchronous and active-high. It sets all scores to 0, hit=miss=0, and state to IDLE.
//   It sets the lock counter to 0 and leader to 0. It also sets kv_q (registered key_valid) to 1,
//   so a key held through reset release is never counted.
//   Reset has priority over all activity, including mid-EVAL and mid-LOCK.
//  Edge detect: kv_q <= key_valid every cycle in every state. An accept requires all of the following:
//   key_valid=1, kv_q=0, state IDLE, and player_sel < PLAYERS.
//   Edges in EVAL or LOCK are dropped, not queued. Edges with out-of-range player_sel are dropped.
//  FSM: IDLE -> EVAL on accept. On accept, the block registers eq = (key_value == target_value) and latches player_sel.
//   EVAL -> LOCK on the next cycle. On this transition the block updates the score and registers hit=eq and miss=~eq.
//   The lock counter loads LOCK_CYCLES-1.
//   LOCK: the counter decrements each cycle. When it is 0, the next state is IDLE.
//   busy = (state != IDLE).
//  Latency: if the accept edge is clock N, then score, hit and miss are visible after edge N+1.
//   The earliest next accept is at edge N+2+LOCK_CYCLES.
//  Hit arithmetic: BCD +1 with per-digit carry (9 -> 0, carry into the next digit).
//   If the score is all 9s: WRAP_ON_MAX=1 gives all 0s; WRAP_ON_MAX=0 holds the score.
//   The hit pulse fires in both cases.
//  Miss arithmetic: BCD -1 with per-digit borrow (0 -> 9, borrow from the next digit).
//   If the score is 0, it holds at 0; the miss pulse still fires.
//  Only the latched player's score changes; all other channels hold.
//  Digits never leave the range 0..9.
//  leader: combinational from the score registers. Compare scores as unsigned BCD magnitudes.
// TESTING
//  1) Reset, PLAYERS=2. Rise key_valid once with key=5, target=5, sel=0.
//     Required: hit pulses for 1 cycle 2 edges after the accept; score0=01; busy for 1+4 cycles; miss stays 0.
//  2) Hold key_valid high for 20 cycles, key=5, target=5.
//     Required: exactly one hit. Then release and rise again with key=3 -> miss; score0 returns to 00.
//  3) From score0=19, hit -> 20 (carry).
//     From 00, miss -> 00 with a miss pulse.
//     From 99: WRAP_ON_MAX=0 -> 99; WRAP_ON_MAX=1 -> 00.
//  4) Give a second rising edge during LOCK.
//     Required: it is ignored; the score changes only once; no hit or miss for the second edge.
//  5) Set score0=03 and score1=03 -> leader=0.
//     Hit on sel=1 -> leader=1; score0 is unchanged. Entry with sel=2 (PLAYERS=2) -> no state change.
//  6) Assert reset during EVAL.
//     Required: no score update, no pulse, IDLE next cycle. With key_valid held through the reset release, there is no accept.

Source files
------------

// File: rtl/nim_score_tracker.sv
// Guess scorer: edge-detects a keypad entry, compares it with the target, adjusts the
// selected player's BCD score, locks out further entries for a while, and reports the leader.
module nim_score_tracker #(
    parameter int VAL_W       = 4,
    parameter int DIGITS      = 2,
    parameter int PLAYERS     = 2,
    parameter int LOCK_CYCLES = 4,
    parameter int WRAP_ON_MAX = 0,
    localparam int PW         = (PLAYERS > 1) ? $clog2(PLAYERS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        key_valid,
    input  logic [VAL_W-1:0]            key_value,
    input  logic [VAL_W-1:0]            target_value,
    input  logic [PW-1:0]               player_sel,
    output logic [PLAYERS*DIGITS*4-1:0] score_bcd,
    output logic                        hit,
    output logic                        miss,
    output logic                        busy,
    output logic [PW-1:0]               leader
);

    localparam int DW = DIGITS * 4;
    localparam int SW = PLAYERS * DW;
    localparam int CW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [DW-1:0] ALL9     = {DIGITS{4'h9}};
    localparam logic [PW:0]   NPLAYERS = (PW+1)'(PLAYERS);

    typedef enum logic [1:0] {IDLE, EVAL, LOCK} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            kv_q;
    logic            eq_q;
    logic [PW-1:0]   sel_q;
    logic [SW-1:0]   score_q, score_d;
    logic            hit_q, miss_q;
    logic            accept;

    function automatic logic [DW-1:0] bcd_inc(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        logic          c;
        r = v;
        c = 1'b1;
        if (v == ALL9) begin
            r = (WRAP_ON_MAX != 0) ? '0 : v;
        end else begin
            for (int unsigned d = 0; d < DIGITS; d++) begin
                if (c) begin
                    if (v[d*4 +: 4] == 4'd9) begin
                        r[d*4 +: 4] = 4'd0;
                    end else begin
                        r[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] bcd_dec(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        logic          b;
        r = v;
        b = 1'b1;
        if (v != '0) begin
            for (int unsigned d = 0; d < DIGITS; d++) begin
                if (b) begin
                    if (v[d*4 +: 4] == 4'd0) begin
                        r[d*4 +: 4] = 4'd9;
                    end else begin
                        r[d*4 +: 4] = v[d*4 +: 4] - 4'd1;
                        b = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    assign accept = key_valid && !kv_q && (state_q == IDLE) && ({1'b0, player_sel} < NPLAYERS);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (accept) state_d = EVAL;
            EVAL: begin
                state_d = LOCK;
                cnt_d   = CW'(LOCK_CYCLES - 1);
            end
            LOCK: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    always_comb begin
        score_d = score_q;
        for (int unsigned p = 0; p < PLAYERS; p++) begin
            if (state_q == EVAL && sel_q == PW'(p)) begin
                score_d[p*DW +: DW] = eq_q ? bcd_inc(score_q[p*DW +: DW])
                                           : bcd_dec(score_q[p*DW +: DW]);
            end
        end
    end

    // kv_q resets high so a key held across reset release never looks like a new edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            kv_q    <= 1'b1;
            eq_q    <= 1'b0;
            sel_q   <= '0;
            score_q <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            kv_q    <= key_valid;
            score_q <= score_d;
            hit_q   <= (state_q == EVAL) && eq_q;
            miss_q  <= (state_q == EVAL) && !eq_q;
            if (accept) begin
                eq_q  <= (key_value == target_value);
                sel_q <= player_sel;
            end
        end
    end

    // Packed BCD compares correctly as plain unsigned; strict > keeps ties on the lower index.
    always_comb begin
        logic [DW-1:0] best;
        leader = '0;
        best   = score_q[DW-1:0];
        for (int unsigned p = 1; p < PLAYERS; p++) begin
            if (score_q[p*DW +: DW] > best) begin
                best   = score_q[p*DW +: DW];
                leader = PW'(p);
            end
        end
    end

    assign score_bcd = score_q;
    assign hit       = hit_q;
    assign miss      = miss_q;

endmodule
